rng_request_arbiter: RTL
========================

Name: rng_request_arbiter

Overview:
- Shares one free-running 24-bit LFSR PRNG between NREQ requesters, such as game-logic blocks needing dice rolls or spawn positions.
- Arbitrates round-robin between requesters.
- Turns raw PRNG bits into a uniform value in [0, bound] using mask-and-reject sampling with a bounded retry count.
- Sits beside the prng instance. Its random-word input comes from the prng output, so the bench can drive it directly.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 24, width of the PRNG word on rnd_i
- BW, 8, width of bound and result (BW <= N)
- MAX_TRIES, 4, number of DRAW cycles before the fallback result is used (>= 1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rnd_i  in  N  current PRNG word; changes every cycle
- req  in  NREQ  request level per requester; held high until its ack
- bound  in  NREQ*BW  inclusive upper bound per requester; slice i = bound[i*BW +: BW]
- ack  out  NREQ  one-hot, one-cycle pulse marking a completed request
- data  out  BW  result; valid only while ack is nonzero
- busy  out  1  high in DRAW and DONE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; ack = 0; data = 0; busy = 0; tries = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - Reset asserted mid-operation discards any draw in progress and produces no ack.
- IDLE:
  - If req != 0, grant the first requester at or after the pointer, wrapping modulo NREQ.
  - Latch sel = index, bnd = bound slice, mask = smallest (2^k - 1) >= bnd. The mask is built by OR-smearing bnd to the right.
  - Go to DRAW with tries = 0.
  - If req == 0, stay in IDLE.
- DRAW (one candidate per cycle):
  - cand = rnd_i[BW-1:0] & mask.
  - If req[sel] == 0, abort: go to IDLE, no ack, pointer unchanged.
  - Else if cand <= bnd: result = cand, go to DONE.
  - Else if tries == MAX_TRIES-1: result = cand - (bnd+1), go to DONE. This is the fallback; it is always in range because cand <= 2*bnd+1.
  - Else tries++ and stay in DRAW.
- DONE (single cycle):
  - ack[sel] = 1, data = result.
  - Pointer = (sel+1) mod NREQ.
  - Next state IDLE.
  - All outputs are registered.
- Latency:
  - Request seen in IDLE at edge k → DRAW at k+1 → DONE at k+2 at the earliest; ack is high for the cycle after edge k+2.
  - Worst case is MAX_TRIES+2 cycles after the request is sampled.
- Handshake:
  - The requester drops req in the cycle ack is high. It is not sampled again until IDLE.
  - If req[sel] is still high when the block returns to IDLE, it counts as a new request, but it has lowest priority after the pointer update.
- Bound width and latching:
  - bound changes after the grant are ignored because bnd is latched.
  - bnd = 0 gives mask = 0 and result 0 on the first DRAW cycle.
  - bnd = 2^BW - 1 gives mask all ones and always accepts.
  - All compare and subtract arithmetic is BW bits wide. bnd+1 is computed at BW+1 bits, so bnd = 2^BW - 1 does not overflow.
- Simultaneous events:
  - Only one request is in flight at a time; no other ack fires during DRAW.
  - A new req arriving during DRAW or DONE waits for IDLE.
- Stall: rnd_i stuck at one value forces the fallback after MAX_TRIES draws, so the block never hangs.

Decomposition:
- Package rng_arb_pkg:
  - state enum {IDLE, DRAW, DONE}
  - function range_mask(bnd) returning the smeared mask
  - localparam PTR_W = $clog2(NREQ)
- Sub-module rr_pick (combinational): inputs req and pointer; outputs grant_valid and grant_idx. This is reusable by other shared-resource arbiters.
- Top level: the FSM, latches, the tries counter and the output registers.

Test Plan:
- Basic accept: req=4'b0001, bound0=9; rnd_i low byte 0x0F, then 0x25.
  - First draw: 15 > 9, reject.
  - Second draw: cand 5, accept.
  - ack=4'b0001 and data=5 for one cycle, 4 cycles after req is sampled.
- Fallback: MAX_TRIES=4, bound0=9, rnd_i held at 0xFFFFFF.
  - Four rejections.
  - ack with data = 15-10 = 5, 6 cycles after req is sampled.
- Round-robin: req=4'b1111 held, every bound=255, rnd_i=0x0000AB.
  - acks appear in order 0,1,2,3,0, each with data=0xAB.
  - Edge bounds: bound=0 gives data=0 after one DRAW cycle.
- Abort and reset:
  - Abort: req0 dropped during DRAW while req2 is held → no ack0; requester 2 is served next; pointer is still 0 before that grant.
  - Reset: reset_n pulsed low mid-DRAW → ack=0, data=0, busy=0 immediately; after release, req=4'b1000 is served first.

Source files
------------

// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the PRNG request arbiter.
package rng_arb_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

  // Pointer width covers the largest supported requester count (8).
  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = $clog2(NREQ_MAX);

  // Smear the bound rightwards: smallest 2^k-1 that is >= bnd.
  function automatic logic [31:0] range_mask(input logic [31:0] bnd);
    logic [31:0] m;
    m = bnd;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rng_request_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick
  import rng_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);
  localparam int SW = PTR_W + 1;

  logic [NREQ-1:0] rot;
  logic [SW-1:0]   sum;

  assign rot = NREQ'({req, req} >> ptr);

  // Scan from the far end so the nearest requester after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid = 1'b1;
        sum         = {1'b0, ptr} + SW'(i);
        grant_idx   = (sum >= SW'(NREQ)) ? PTR_W'(sum - SW'(NREQ)) : PTR_W'(sum);
      end
    end
  end

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one PRNG word stream between NREQ requesters; returns a uniform
// value in [0, bound] by mask-and-reject with a bounded retry fallback.
module rng_request_arbiter
  import rng_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int N         = 24,
  parameter int BW        = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      rnd_i,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*BW-1:0] bound,
  output logic [NREQ-1:0]   ack,
  output logic [BW-1:0]     data,
  output logic              busy
);
  localparam int NP = 2 ** PTR_W;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [NREQ-1:0] LSB1 = NREQ'(1);

  state_e                    state;
  logic [PTR_W-1:0]          ptr, sel, gi;
  logic                      gv;
  logic [BW-1:0]             bnd, mask, result, cand, fallback;
  logic [BW:0]               bnd1;
  logic [TW-1:0]             tries;
  logic [NP-1:0]             req_ext;
  logic [NP-1:0][BW-1:0]     bnd_arr;

  // Padded to the pointer range so any index value selects cleanly.
  for (genvar i = 0; i < NP; i++) begin : g_bnd
    if (i < NREQ) begin : g_v
      assign bnd_arr[i] = bound[i*BW +: BW];
    end else begin : g_z
      assign bnd_arr[i] = '0;
    end
  end

  if (N > BW) begin : g_unused
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd_i[N-1:BW];
  end

  assign req_ext  = NP'(req);
  assign cand     = rnd_i[BW-1:0] & mask;
  assign bnd1     = {1'b0, bnd} + 1'b1;
  // cand <= 2*bnd+1 on a reject, so this stays within [0, bnd].
  assign fallback = BW'({1'b0, cand} - bnd1);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .ptr        (ptr),
    .grant_valid(gv),
    .grant_idx  (gi)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      sel    <= '0;
      bnd    <= '0;
      mask   <= '0;
      tries  <= '0;
      result <= '0;
      ack    <= '0;
      data   <= '0;
      busy   <= 1'b0;
    end else begin
      ack  <= '0;
      data <= '0;
      case (state)
        IDLE: if (gv) begin
          sel   <= gi;
          bnd   <= bnd_arr[gi];
          mask  <= BW'(range_mask(32'(bnd_arr[gi])));
          tries <= '0;
          busy  <= 1'b1;
          state <= DRAW;
        end
        DRAW: begin
          if (!req_ext[sel]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cand <= bnd) begin
            result <= cand;
            state  <= DONE;
          end else if (tries == TW'(MAX_TRIES - 1)) begin
            result <= fallback;
            state  <= DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        DONE: begin
          ack   <= LSB1 << sel;
          data  <= result;
          ptr   <= (sel == PTR_W'(NREQ - 1)) ? '0 : sel + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
